// File: rtl/counter_ctrl_pkg.sv
// Shared opcode and FSM state types for the counter command scheduler.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters starting at ptr, wrapping modulo N; take the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = PW'((int'(ptr) + k) % int'(N));
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_scheduler.sv
// Arbitrates requesters onto one shared up/down counter and sequences its controls.
module counter_cmd_scheduler
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_arg,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output logic [WIDTH-1:0]      steps,
  output logic                  cnt_rst_n,
  output logic                  cnt_load_n,
  output logic                  cnt_up_down,
  output logic                  cnt_ce,
  output logic [WIDTH-1:0]      cnt_data_load,
  input  logic [WIDTH-1:0]      cnt_count_out,
  input  logic                  cnt_max_count,
  input  logic                  cnt_zero
);

  localparam int unsigned PW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    win_q;
  op_e              op_q;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] rem_q;

  logic [NREQ-1:0]  win_oh;
  logic [PW-1:0]    win_idx;
  op_e              win_op;
  logic [WIDTH-1:0] win_arg;
  logic             accept;
  logic             bnd;
  logic             run_step;

  // Boundary decisions use live flags only; the count value itself is not needed.
  logic unused_count;
  assign unused_count = ^cnt_count_out;

  assign cnt_rst_n = rst_n;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign accept    = (state_q == IDLE) && (|req);

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (win_oh)
  );

  // Decode the winner's index, opcode and argument from the one-hot grant.
  always_comb begin
    win_idx = '0;
    win_op  = OP_LOAD;
    win_arg = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_oh[i]) begin
        win_idx = PW'(i);
        win_op  = op_e'(req_op[2*i +: 2]);
        win_arg = req_arg[WIDTH*i +: WIDTH];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and counter control decode; ce in RUN reacts to live flags.
  always_comb begin
    state_d       = state_q;
    cnt_load_n    = 1'b1;
    cnt_ce        = 1'b0;
    cnt_up_down   = 1'b0;
    cnt_data_load = '0;
    run_step      = 1'b0;
    bnd           = (op_q == OP_UP) ? cnt_max_count : cnt_zero;
    case (state_q)
      IDLE: begin
        if (|req) state_d = (win_op == OP_UP || win_op == OP_DOWN) ? RUN : LOAD;
      end
      LOAD: begin
        cnt_load_n    = 1'b0;
        cnt_ce        = 1'b1;
        cnt_data_load = (op_q == OP_LOAD) ? arg_q : '0;
        state_d       = DONE;
      end
      RUN: begin
        cnt_up_down = (op_q == OP_UP);
        if (rem_q == '0 || bnd) begin
          state_d = DONE;
        end else begin
          cnt_ce   = 1'b1;
          run_step = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, step bookkeeping, grant and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      win_q <= '0;
      grant <= '0;
      op_q  <= OP_LOAD;
      arg_q <= '0;
      rem_q <= '0;
      steps <= '0;
      hit   <= 1'b0;
    end else begin
      if (accept) begin
        grant <= win_oh;
        win_q <= win_idx;
        op_q  <= win_op;
        arg_q <= win_arg;
        rem_q <= win_arg;
        steps <= '0;
        hit   <= 1'b0;
      end
      if (state_q == RUN) begin
        if (run_step) begin
          rem_q <= rem_q - WIDTH'(1);
          steps <= steps + WIDTH'(1);
        end else if (rem_q != '0) begin
          hit <= 1'b1;
        end
      end
      if (state_q == DONE) begin
        grant <= '0;
        ptr_q <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_scheduler.sv
// Directed bench: scheduler driving a behavioural up/down loadable counter.
module tb_counter_cmd_scheduler;

  localparam int W = 4;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_arg;
  logic [N-1:0]   grant;
  logic           busy, done, hit;
  logic [W-1:0]   steps;
  logic           cnt_rst_n, cnt_load_n, cnt_up_down, cnt_ce;
  logic [W-1:0]   cnt_data_load;
  logic [W-1:0]   cnt;
  logic           cnt_max_count, cnt_zero;

  int total = 0;
  int bad   = 0;

  counter_cmd_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_op        (req_op),
    .req_arg       (req_arg),
    .grant         (grant),
    .busy          (busy),
    .done          (done),
    .hit           (hit),
    .steps         (steps),
    .cnt_rst_n     (cnt_rst_n),
    .cnt_load_n    (cnt_load_n),
    .cnt_up_down   (cnt_up_down),
    .cnt_ce        (cnt_ce),
    .cnt_data_load (cnt_data_load),
    .cnt_count_out (cnt),
    .cnt_max_count (cnt_max_count),
    .cnt_zero      (cnt_zero)
  );

  always #5 clk = ~clk;

  // Shared counter: async reset, sync active-low load, enable, up/down.
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)       cnt <= '0;
    else if (!cnt_load_n) cnt <= cnt_data_load;
    else if (cnt_ce)      cnt <= cnt_up_down ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign cnt_max_count = (cnt == 4'hF);
  assign cnt_zero      = (cnt == 4'h0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one command from requester idx and observe it through its done pulse.
  task automatic run_cmd(input int idx, input logic [1:0] op, input logic [3:0] arg,
                         output logic [2:0] g, output int nce, output int upc,
                         output int nld, output logic [3:0] ldv, output logic h,
                         output logic [3:0] st, output logic [3:0] cv);
    bit got;
    g = '0; nce = 0; upc = 0; nld = 0; ldv = '0; h = 1'b0; st = '0; cv = '0;
    got = 1'b0;
    @(negedge clk);
    req_op[2*idx +: 2]  = op;
    req_arg[4*idx +: 4] = arg;
    req[idx]            = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) g = grant;
      if (cnt_ce) nce++;
      if (cnt_ce && cnt_up_down) upc++;
      if (!cnt_load_n) begin nld++; ldv = cnt_data_load; end
      if (done) begin
        h = hit; st = steps; cv = cnt; got = 1'b1;
        req[idx] = 1'b0;
        break;
      end
    end
    if (!got) begin
      chk("cmd_timeout", 32'(0), 32'(1));
      req[idx] = 1'b0;
    end
  endtask

  logic [2:0] g;
  int         nce, upc, nld;
  logic [3:0] ldv, st, cv;
  logic       h;
  logic [2:0] gs [3];
  logic [3:0] cs [3];
  bit         got;

  initial begin
    rst_n = 1'b0; req = '0; req_op = '0; req_arg = '0;
    #1;
    chk("rst_grant",     32'(grant), 32'(0));
    chk("rst_busy",      32'(busy), 32'(0));
    chk("rst_done",      32'(done), 32'(0));
    chk("rst_hit",       32'(hit), 32'(0));
    chk("rst_steps",     32'(steps), 32'(0));
    chk("rst_load_n",    32'(cnt_load_n), 32'(1));
    chk("rst_ce",        32'(cnt_ce), 32'(0));
    chk("rst_up_down",   32'(cnt_up_down), 32'(0));
    chk("rst_data_load", 32'(cnt_data_load), 32'(0));
    chk("rst_cnt_rst_n", 32'(cnt_rst_n), 32'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // LOAD 9 from requester 0
    run_cmd(0, 2'b00, 4'd9, g, nce, upc, nld, ldv, h, st, cv);
    chk("load9_grant", 32'(g), 32'(3'b001));
    chk("load9_nld",   32'(nld), 32'(1));
    chk("load9_ldv",   32'(ldv), 32'(9));
    chk("load9_cnt",   32'(cv), 32'(9));
    chk("load9_hit",   32'(h), 32'(0));
    chk("load9_steps", 32'(st), 32'(0));
    @(negedge clk);
    chk("load9_busy_after",  32'(busy), 32'(0));
    chk("load9_grant_after", 32'(grant), 32'(0));

    // Count 3, UP 5 from requester 1: unobstructed run
    run_cmd(1, 2'b00, 4'd3, g, nce, upc, nld, ldv, h, st, cv);
    chk("load3_cnt", 32'(cv), 32'(3));
    run_cmd(1, 2'b01, 4'd5, g, nce, upc, nld, ldv, h, st, cv);
    chk("up5_grant", 32'(g), 32'(3'b010));
    chk("up5_ce",    32'(nce), 32'(5));
    chk("up5_updn",  32'(upc), 32'(5));
    chk("up5_hit",   32'(h), 32'(0));
    chk("up5_steps", 32'(st), 32'(5));
    chk("up5_cnt",   32'(cv), 32'(8));

    // Count 13, UP 6 from requester 2: stops at max
    run_cmd(2, 2'b00, 4'd13, g, nce, upc, nld, ldv, h, st, cv);
    chk("load13_cnt", 32'(cv), 32'(13));
    run_cmd(2, 2'b01, 4'd6, g, nce, upc, nld, ldv, h, st, cv);
    chk("up6_ce",    32'(nce), 32'(2));
    chk("up6_hit",   32'(h), 32'(1));
    chk("up6_steps", 32'(st), 32'(2));
    chk("up6_cnt",   32'(cv), 32'(15));
    @(negedge clk); @(negedge clk);
    chk("up6_cnt_hold", 32'(cnt), 32'(15));

    // Count 2, DOWN 0 then DOWN 4 from requester 0
    run_cmd(0, 2'b00, 4'd2, g, nce, upc, nld, ldv, h, st, cv);
    run_cmd(0, 2'b10, 4'd0, g, nce, upc, nld, ldv, h, st, cv);
    chk("dn0_ce",    32'(nce), 32'(0));
    chk("dn0_hit",   32'(h), 32'(0));
    chk("dn0_steps", 32'(st), 32'(0));
    chk("dn0_cnt",   32'(cv), 32'(2));
    run_cmd(0, 2'b10, 4'd4, g, nce, upc, nld, ldv, h, st, cv);
    chk("dn4_ce",    32'(nce), 32'(2));
    chk("dn4_updn",  32'(upc), 32'(0));
    chk("dn4_hit",   32'(h), 32'(1));
    chk("dn4_steps", 32'(st), 32'(2));
    chk("dn4_cnt",   32'(cv), 32'(0));

    // Requester 2 last served, so the pointer returns to 0
    run_cmd(2, 2'b00, 4'd6, g, nce, upc, nld, ldv, h, st, cv);
    chk("load6_cnt", 32'(cv), 32'(6));

    // All three requesting: served 0, 1, 2
    @(negedge clk);
    req_op  = {2'b00, 2'b00, 2'b00};
    req_arg = {4'd3, 4'd2, 4'd1};
    req     = 3'b111;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      gs[k] = '0;
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        if (done) begin
          gs[k] = grant; cs[k] = cnt;
          req = req & ~grant;
          got = 1'b1;
          break;
        end
      end
      if (!got) chk("allreq_timeout", 32'(0), 32'(1));
    end
    chk("allreq_g0",  32'(gs[0]), 32'(3'b001));
    chk("allreq_g1",  32'(gs[1]), 32'(3'b010));
    chk("allreq_g2",  32'(gs[2]), 32'(3'b100));
    chk("allreq_cnt", 32'(cs[2]), 32'(3));

    // Requesters 0 (UP 1) and 2 (CLEAR) together, pointer at 0
    @(negedge clk);
    req_op  = {2'b11, 2'b00, 2'b01};
    req_arg = {4'd9, 4'd0, 4'd1};
    req     = 3'b101;
    for (int k = 0; k < 2; k++) begin
      got = 1'b0;
      gs[k] = '0;
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        if (done) begin
          gs[k] = grant; cs[k] = cnt;
          req = req & ~grant;
          got = 1'b1;
          break;
        end
      end
      if (!got) chk("pair_timeout", 32'(0), 32'(1));
    end
    chk("pair_g0",   32'(gs[0]), 32'(3'b001));
    chk("pair_cnt0", 32'(cs[0]), 32'(4));
    chk("pair_g1",   32'(gs[1]), 32'(3'b100));
    chk("clear_cnt", 32'(cs[1]), 32'(0));

    // Reset in the middle of an UP run
    run_cmd(0, 2'b00, 4'd5, g, nce, upc, nld, ldv, h, st, cv);
    chk("load5_cnt", 32'(cv), 32'(5));
    @(negedge clk);
    req_op[3:2]  = 2'b01;
    req_arg[7:4] = 4'd3;
    req[1]       = 1'b1;
    @(negedge clk);
    chk("midrun_ce",    32'(cnt_ce), 32'(1));
    chk("midrun_grant", 32'(grant), 32'(3'b010));
    rst_n = 1'b0;
    #1;
    chk("arst_ce",    32'(cnt_ce), 32'(0));
    chk("arst_grant", 32'(grant), 32'(0));
    chk("arst_busy",  32'(busy), 32'(0));
    chk("arst_done",  32'(done), 32'(0));
    chk("arst_cnt",   32'(cnt), 32'(0));
    req[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'(0));
    end
    rst_n = 1'b1;
    run_cmd(0, 2'b00, 4'd7, g, nce, upc, nld, ldv, h, st, cv);
    chk("post_rst_grant", 32'(g), 32'(3'b001));
    chk("post_rst_cnt",   32'(cv), 32'(7));
    chk("post_rst_steps", 32'(st), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_cmd_scheduler.md
Name: counter_cmd_scheduler

Overview:
- Shares one up/down loadable counter between NREQ requesters.
- Each requester issues a command: LOAD, CLEAR, count UP n steps, or count DOWN n steps.
- The block arbitrates round-robin, then sequences the counter's load_n/ce/up_down/data_load controls to execute the command.
- It stops a run early when the counter's max_count/zero flag is hit, and returns done/hit/steps to the granted requester.

Parameters:
- WIDTH, 4, counter data width; matches the counter's WIDTH.
- NREQ, 3, number of requesters (≥2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- req  input  NREQ  per-requester command request; hold high with op/arg stable until done.
- req_op  input  2*NREQ  per-requester opcode, slice i = [2i+1:2i]. 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
- req_arg  input  WIDTH*NREQ  per-requester argument: load value, or step count for UP/DOWN.
- grant  output  NREQ  one-hot owner, high from accept through the done cycle.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse for the granted requester.
- hit  output  1  valid with done; run ended on a counter boundary flag.
- steps  output  WIDTH  valid with done; number of ce pulses issued.
- cnt_rst_n  output  1  counter reset, driven = rst_n.
- cnt_load_n  output  1  counter synchronous load, active-low.
- cnt_up_down  output  1  1 = up, 0 = down.
- cnt_ce  output  1  counter enable.
- cnt_data_load  output  WIDTH  counter load value.
- cnt_count_out  input  WIDTH  counter value.
- cnt_max_count  input  1  counter at all-ones.
- cnt_zero  input  1  counter at zero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer=0.
  - grant=0, busy=0, done=0, hit=0, steps=0.
  - cnt_load_n=1, cnt_ce=0, cnt_up_down=0, cnt_data_load=0.
  - A reset mid-command abandons it; no done is issued.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req != 0, a round-robin winner is chosen, starting the search at the pointer.
  - On that edge: grant <= onehot(winner); op/arg are latched; rem <= arg; steps <= 0; hit <= 0.
  - Next state: LOAD for LOAD/CLEAR, RUN for UP/DOWN.
  - No req → stay in IDLE.
  - Latency from req sampled to grant visible is 1 cycle.
- LOAD (exactly 1 cycle):
  - cnt_load_n=0, cnt_ce=1.
  - cnt_data_load = arg for LOAD, 0 for CLEAR.
  - Next state: DONE. steps=0.
- RUN, evaluated every cycle:
  - bnd = cnt_max_count if UP, cnt_zero if DOWN.
  - cnt_up_down = (op==UP) throughout RUN.
  - rem==0 → cnt_ce=0, go to DONE, hit=0.
  - Else bnd=1 → cnt_ce=0, go to DONE, hit=1.
  - Else → cnt_ce=1, rem--, steps++.
  - cnt_ce is combinational on the counter flags (Mealy), so the counter is never wrapped by this block.
  - arg=0 → no ce pulses; done follows after one RUN cycle.
  - A RUN of n unobstructed steps occupies n+1 cycles.
- DONE (1 cycle):
  - done=1; grant, hit and steps held.
  - rr pointer <= winner+1 mod NREQ.
  - Next state: IDLE; grant clears on that edge.
- Requester rule: req must be low in the cycle after done; otherwise it is regranted.
- Changes to op/arg while granted are ignored.
- Requests from non-granted requesters stay pending.
- Outside LOAD/RUN: cnt_load_n=1, cnt_ce=0.
- LOAD does not check flags.
- Counter value is never cached; boundary decisions always use live flags.

Decomposition:
- Package counter_ctrl_pkg holds:
  - op_e enum {OP_LOAD=2'b00, OP_UP=2'b01, OP_DOWN=2'b10, OP_CLEAR=2'b11}.
  - state_e enum {IDLE, LOAD, RUN, DONE}.
- Sub-module rr_arbiter (parameter N) takes req and pointer and returns a one-hot winner combinationally.
- The scheduler owns the pointer register, the FSM and the counter-control decode.

Test Plan (WIDTH=4, NREQ=3, scheduler wired to the up/down counter):
- Reset, then req[0] LOAD 9 → grant=001 next cycle; one cycle of cnt_load_n=0 with data_load=9; done next cycle; count_out=9, hit=0, steps=0; busy low after done.
- Count=3, req[1] UP 5 → 5 consecutive ce cycles with up_down=1; count=8; done with hit=0, steps=5.
- Count=13, req[2] UP 6 → 2 ce pulses; count=15, max_count=1; done with hit=1, steps=2; count stays 15.
- Count=2: req[0] DOWN 0 → done, steps=0, no ce, count 2. Then DOWN 4 → 2 pulses, count=0, hit=1, steps=2.
- All req high with pointer=0, each dropping after its done → grants 001, 010, 100 in order. Then req[0] and req[2] together with pointer=0 → 001 before 100. CLEAR from req[2] → count 0.
- rst_n=0 during an UP run (count=5, rem=3) → cnt_ce=0 and grant=0 immediately (async); no done pulse; after release, state is IDLE and the next req is granted normally.
